wb_sel_stage: RTL

//  Write-back result stage: the result-side counterpart of the ALU B-operand select.
//  - Accepts one retired instruction per handshake.
//  - Selects the register-file write data from the ALU result, PC+4, the immediate or load data.
//  - For loads, waits for the data-memory response, then extracts and sign/zero-extends the loaded value.
//  - Drives the register-file write port for exactly one cycle per writing instruction.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/wb_sel_stage_load_extend.sv | 29 ++
 rtl/wb_sel_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings for the write-back stage: opcodes, load funct3 codes and stage states.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LD = 2'd1,
        WB      = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_sel_stage_load_extend.sv
// load_extend: picks the addressed byte/half/word out of a memory word and sign/zero-extends it.
module load_extend
    import riscv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] word,
    input  logic [1:0]   off,
    input  logic [2:0]   funct3,
    output logic [W-1:0] value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfword selection only looks at off[1]; an odd offset is not shifted further.
    always_comb begin
        byte_v = word[{off, 3'b000} +: 8];
        half_v = word[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   value = {{(W-8){byte_v[7]}}, byte_v};
            F3_LBU:  value = {{(W-8){1'b0}}, byte_v};
            F3_LH:   value = {{(W-16){half_v[15]}}, half_v};
            F3_LHU:  value = {{(W-16){1'b0}}, half_v};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/wb_sel_stage.sv
// wb_sel_stage: selects register-file write data and waits on the memory response for loads.
// Optional WB_SEL_MISALIGN_EN adds a sticky misalign_err output and suppresses misaligned load writes.
module wb_sel_stage
    import riscv_pkg::*;
#(
    parameter int W     = 32,
    parameter int OPLEN = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPLEN-1:0] op,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rd,
    input  logic [W-1:0]     alu_res,
    input  logic [W-1:0]     pc_plus4,
    input  logic [W-1:0]     imm,
    input  logic [W-1:0]     mem_rdata,
    input  logic             mem_rvalid,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [W-1:0]     rf_wdata,
    output logic             busy
`ifdef WB_SEL_MISALIGN_EN
    , output logic           misalign_err
`endif
);

    wb_state_t      state, state_n;
    logic           accept;
    logic           ld_capture;
    logic           we_n;
    logic [4:0]     waddr_n;
    logic [W-1:0]   wdata_n;
    logic [4:0]     ld_rd;
    logic [2:0]     ld_f3;
    logic [1:0]     ld_off;
    logic           ld_bad;
    logic [W-1:0]   ld_value;

    assign in_ready = (state != WAIT_LD);
    assign busy     = (state == WAIT_LD);
    assign accept   = in_valid && in_ready;

    load_extend #(.W(W)) u_extend (
        .word   (mem_rdata),
        .off    (ld_off),
        .funct3 (ld_f3),
        .value  (ld_value)
    );

    // Writes are registered one cycle after accept (or after the memory response); x0 is never written.
    always_comb begin
        state_n    = state;
        we_n       = 1'b0;
        waddr_n    = rf_waddr;
        wdata_n    = rf_wdata;
        ld_capture = 1'b0;
        case (state)
            IDLE, WB: begin
                state_n = IDLE;
                if (accept) begin
                    case (op)
                        OP_R, OP_I, OP_AUIPC: begin
                            state_n = WB;
                            we_n    = (rd != 5'd0);
                            waddr_n = rd;
                            wdata_n = alu_res;
                        end
                        OP_LUI: begin
                            state_n = WB;
                            we_n    = (rd != 5'd0);
                            waddr_n = rd;
                            wdata_n = imm;
                        end
                        OP_JAL, OP_JALR: begin
                            state_n = WB;
                            we_n    = (rd != 5'd0);
                            waddr_n = rd;
                            wdata_n = pc_plus4;
                        end
                        OP_LOAD: begin
                            state_n    = WAIT_LD;
                            ld_capture = 1'b1;
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
            WAIT_LD: begin
                if (mem_rvalid) begin
                    state_n = WB;
                    we_n    = (ld_rd != 5'd0) && !ld_bad;
                    waddr_n = ld_rd;
                    wdata_n = ld_value;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
            ld_rd    <= 5'd0;
            ld_f3    <= 3'd0;
            ld_off   <= 2'd0;
        end else begin
            state    <= state_n;
            rf_we    <= we_n;
            rf_waddr <= waddr_n;
            rf_wdata <= wdata_n;
            if (ld_capture) begin
                ld_rd  <= rd;
                ld_f3  <= funct3;
                ld_off <= alu_res[1:0];
            end
        end
    end

`ifdef WB_SEL_MISALIGN_EN
    logic bad_now;

    assign bad_now = (((funct3 == F3_LH) || (funct3 == F3_LHU)) && alu_res[0]) ||
                     ((funct3 == F3_LW) && (alu_res[1:0] != 2'b00));

    // The misaligned load still drains its memory response; only its write is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_bad       <= 1'b0;
            misalign_err <= 1'b0;
        end else if (ld_capture) begin
            ld_bad <= bad_now;
            if (bad_now) begin
                misalign_err <= 1'b1;
            end
        end
    end
`else
    assign ld_bad = 1'b0;
`endif

endmodule
